// File: rtl/tft_bus_arbiter.sv
// tft_bus_arbiter: round-robin owner of the single TFT byte interface.
// Each grant is held for a whole burst, so bytes from different drawing
// engines never interleave on the panel. An idle watchdog revokes a grant
// whose owner goes silent for IDLE_TO cycles.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   req           per-requester burst request (level, held for the burst)
//   req_dc        per-requester dc bit (0 = command, 1 = data)
//   req_data      per-requester byte, requester i on bits [8i+7:8i]
//   req_transmit  per-requester one-cycle byte strobe
//   grant         one-hot (or zero) current owner
//   req_busy      per-requester busy, fed to each engine's tft_busy input
//   timeout       one-cycle pulse when the watchdog revokes a grant
//   tft_busy      serializer busy
//   tft_dc, tft_data, tft_transmit   muxed byte interface to the serializer
module tft_bus_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDLE_TO = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_dc,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_transmit,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     req_busy,
  output logic                   timeout,
  input  logic                   tft_busy,
  output logic                   tft_dc,
  output logic [7:0]             tft_data,
  output logic                   tft_transmit
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SW = PW + 1;
  localparam int unsigned CW = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_TO - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      own_q, own_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] revoked_q, revoked_d;
  logic               dc_q, dc_d;
  logic [7:0]         data_q, data_d;
  logic               tx_q, tx_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] eligible;
  logic [SW-1:0]      cand;
  logic               pick_found;
  logic [PW-1:0]      pick_idx;
  logic [PW-1:0]      next_own;

  // A revoked requester stays ineligible until it drops req.
  assign eligible = req & ~revoked_q;
  assign next_own = (own_q == PW'(NUM_REQ - 1)) ? '0 : own_q + PW'(1);

  // Owner sees the serializer (plus the byte in flight); everyone else is held off.
  assign req_busy     = ~grant_q | {NUM_REQ{tft_busy | tx_q}};
  assign grant        = grant_q;
  assign timeout      = timeout_q;
  assign tft_dc       = dc_q;
  assign tft_data     = data_q;
  assign tft_transmit = tx_q;

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    own_d      = own_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    revoked_d  = revoked_q & req;
    dc_d       = dc_q;
    data_d     = data_q;
    tx_d       = 1'b0;
    timeout_d  = 1'b0;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;

    // First eligible requester at or after ptr, wrapping.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = SW'(ptr_q) + SW'(k);
      if (cand >= SW'(NUM_REQ)) cand = cand - SW'(NUM_REQ);
      if (!pick_found && eligible[cand[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          own_d   = pick_idx;
          cnt_d   = '0;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        // Owner byte is always forwarded, even on the cycle req falls.
        dc_d   = req_dc[own_q];
        data_d = req_data[{own_q, 3'b000} +: 8];
        tx_d   = req_transmit[own_q];
        if (!req[own_q]) begin
          grant_d = '0;
          ptr_d   = next_own;
          state_d = ST_DRAIN;
        end else if (req_transmit[own_q]) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d         = 1'b1;
          revoked_d[own_q]  = 1'b1;
          grant_d           = '0;
          ptr_d             = next_own;
          state_d           = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        // Never regrant while the last byte is still being shifted out.
        if (!tx_q && !tft_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      own_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      revoked_q <= '0;
      dc_q      <= 1'b1;
      data_q    <= 8'h00;
      tx_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      revoked_q <= revoked_d;
      dc_q      <= dc_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
